refresh_skip_scheduler: RTL and testbench
=========================================

# refresh_skip_scheduler

Parametrised refresh scheduler for the gain-cell DRAM array. It opens a refresh window at the start of each retention period, tracks which rows are already fresh, and issues refresh requests only for stale rows. A row counts as fresh once it has been refreshed or written by the user in the current window. It sits between the user write path and the refresh engine, and generalises the fixed 128-row skip tracker with a configurable depth, an internal retention timer, a valid/ready refresh handshake, a pending counter and overrun detection.

## Interface
- NUM_ROWS, 128, rows tracked (≥2)
- ADDR_W, $clog2(NUM_ROWS), row address width
- RETENTION_CYCLES, 1024, cycles between automatic window starts (≥2)
- CNT_W, $clog2(NUM_ROWS+1), pending-counter width
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  timer enable; 0 freezes the timer and blocks automatic starts
- start  in  1  one-cycle manual window start; also zeroes the timer
- user_we  in  1  user write strobe
- user_addr  in  ADDR_W  user write/query row
- ref_valid  out  1  refresh request valid
- ref_addr  out  ADDR_W  row to refresh; stable while ref_valid=1
- ref_ready  in  1  refresh engine accepts the request
- user_hit  out  1  registered: row user_addr was fresh before this edge's update
- pending  out  CNT_W  stale rows remaining in the current window
- done  out  1  window complete, or no window open
- overrun  out  1  sticky: a window start arrived while done=0
- overrun_clr  in  1  clears overrun

## Operation
- Each row has one fresh bit. Reset value of all fresh bits is 0.
- States:
  - IDLE: no window open.
  - SCAN: select the lowest-index stale row.
  - REQ: ref_valid=1, waiting for the handshake.
- Window start:
  - Trigger is `start`, or the timer reaching RETENTION_CYCLES-1 while en=1.
  - Effect: all fresh bits cleared, pending=NUM_ROWS, done=0, state SCAN.
- SCAN:
  - If a stale row exists: register it into ref_addr, set ref_valid, go to REQ.
  - If none exists: done=1, go to IDLE.
- REQ:
  - On ref_valid&ref_ready: set the fresh bit of ref_addr, drop ref_valid, go to SCAN.
  - Request is never withdrawn, even if the user writes that row meanwhile. The engine still refreshes it; marking an already-fresh row is harmless.
- User writes:
  - Any user_we sets the fresh bit of user_addr in every state.
  - In IDLE the bit is set and pending is unchanged.
- pending:
  - Decrements once per row that goes stale→fresh while a window is open.
  - Ack and user write to two different stale rows in the same cycle: decrement by 2.
  - Same row: decrement by 1.
  - pending never underflows.
- Window start with done=0:
  - overrun←1 (sticky).
  - In SCAN: restart immediately.
  - In REQ: restart is latched and takes effect on the cycle after the handshake; the handshake completes normally.
- Simultaneous events:
  - User write in the same cycle as a window clear: that row ends fresh (set wins); pending=NUM_ROWS-1.
  - overrun set and overrun_clr in the same cycle: set wins.
  - start and timer expiry in the same cycle: one window start.

## Timing
- Reset values: ref_valid=0, ref_addr=0, user_hit=0, pending=0, done=1, overrun=0, timer=0, state IDLE, all fresh bits 0.
- Window start at edge N: SCAN during cycle N+1; ref_valid=1 after edge N+1.
- Refresh throughput: one accepted request per 2 cycles with ref_ready held high.
- Full window with no skips and ready high: done rises 2·NUM_ROWS+1 cycles after the start edge.
- done rises after the SCAN cycle that finds no stale row.
- user_hit has 1-cycle latency.
- Timer behaviour:
  - Wraps to 0 at RETENTION_CYCLES-1 and produces the start pulse on that edge.
  - `start` forces the timer to 0.
  - Timer is frozen while en=0.
- rst mid-operation returns all state to reset values immediately, including dropping ref_valid.

## Structure
- Package gc_refresh_pkg holds:
  - state enum {IDLE, SCAN, REQ}
  - address-width helper function
  - default NUM_ROWS and RETENTION_CYCLES constants
- Sub-module first_zero_finder: parametrised combinational priority encoder over the fresh bitmap. Outputs are `found` and `index` of the lowest zero.
- Top level holds the FSM, bitmap, timer, pending counter and restart latch.

## Test plan
- Reset, then start with ref_ready=1 and no user writes (NUM_ROWS=128):
  - ref_addr sequence is 0..127.
  - pending steps 128→0.
  - done=1 at 257 cycles after the start edge.
- User writes rows 3, 4 and 127 before their turn:
  - Those rows are never requested.
  - 125 requests are issued.
  - pending reaches 0.
- Hold ref_ready=0 for 10 cycles, and write the requested row 5 mid-wait:
  - ref_valid/ref_addr=5 stay stable throughout.
  - pending decrements once, at the write.
- Ack of row 7 and user write of row 9 in the same cycle: pending drops by 2.
- Fire start while in REQ:
  - Handshake completes.
  - Next cycle the bitmap clears and pending=128.
  - overrun=1 until overrun_clr.
- RETENTION_CYCLES=300, en=1, no manual start:
  - Windows start every 300 cycles.
  - With en=0 no window starts.
  - Async rst mid-window gives done=1, ref_valid=0 immediately.

Source files
------------

// File: rtl/gc_refresh_pkg.sv
// Shared types and constants for the gain-cell DRAM refresh scheduler.
package gc_refresh_pkg;

    localparam int NUM_ROWS_DEFAULT         = 128;
    localparam int RETENTION_CYCLES_DEFAULT = 1024;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        REQ  = 2'd2
    } state_e;

    // Index width for n entries; never below 1 so single-entry vectors stay legal.
    function automatic int addr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/first_zero_finder.sv
// Combinational priority encoder: locates the lowest-index zero in a bitmap.
module first_zero_finder #(
    parameter int WIDTH = 128,
    parameter int IDX_W = 7
) (
    input  logic [WIDTH-1:0] bits,
    output logic             found,
    output logic [IDX_W-1:0] index
);

    // Walk from the top down so the last hit written is the lowest zero.
    always_comb begin
        found = 1'b0;
        index = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!bits[i]) begin
                found = 1'b1;
                index = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/refresh_skip_scheduler.sv
// Refresh scheduler that opens a window per retention period and only
// requests refresh for rows not already refreshed or written in that window.
module refresh_skip_scheduler
    import gc_refresh_pkg::*;
#(
    parameter int NUM_ROWS         = NUM_ROWS_DEFAULT,
    parameter int ADDR_W           = addr_width(NUM_ROWS),
    parameter int RETENTION_CYCLES = RETENTION_CYCLES_DEFAULT,
    parameter int CNT_W            = $clog2(NUM_ROWS + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              start,
    input  logic              user_we,
    input  logic [ADDR_W-1:0] user_addr,
    output logic              ref_valid,
    output logic [ADDR_W-1:0] ref_addr,
    input  logic              ref_ready,
    output logic              user_hit,
    output logic [CNT_W-1:0]  pending,
    output logic              done,
    output logic              overrun,
    input  logic              overrun_clr
);

    localparam int               TMR_W    = addr_width(RETENTION_CYCLES);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(RETENTION_CYCLES - 1);

    state_e              state_q, state_d;
    logic [NUM_ROWS-1:0] fresh_q, fresh_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic [CNT_W-1:0]    pending_q, pending_d;
    logic [ADDR_W-1:0]   ref_addr_q, ref_addr_d;
    logic                ref_valid_q, ref_valid_d;
    logic                restart_q, restart_d;
    logic                overrun_q, overrun_d;
    logic                user_hit_q;

    logic                stale_found;
    logic [ADDR_W-1:0]   stale_idx;
    logic                timer_expire, win_start, win_open, clear;
    logic                ack, ack_new, user_new;
    logic [1:0]          dec;

    first_zero_finder #(
        .WIDTH (NUM_ROWS),
        .IDX_W (ADDR_W)
    ) u_finder (
        .bits  (fresh_q),
        .found (stale_found),
        .index (stale_idx)
    );

    // Retention timer and window-start trigger.
    always_comb begin
        timer_expire = en && (timer_q == TMR_LAST);
        win_start    = start || timer_expire;
        timer_d      = timer_q;
        if (win_start) begin
            timer_d = '0;
        end else if (en) begin
            timer_d = timer_q + TMR_W'(1);
        end
    end

    // FSM: scan for the lowest stale row, hold the request until accepted.
    always_comb begin
        state_d     = state_q;
        ref_valid_d = ref_valid_q;
        ref_addr_d  = ref_addr_q;
        restart_d   = restart_q;
        clear       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (win_start) begin
                    clear   = 1'b1;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (win_start) begin
                    clear = 1'b1;
                end else if (stale_found) begin
                    ref_addr_d  = stale_idx;
                    ref_valid_d = 1'b1;
                    state_d     = REQ;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                // A start during an outstanding request waits for the handshake.
                if (win_start) restart_d = 1'b1;
                if (ref_ready) begin
                    ref_valid_d = 1'b0;
                    state_d     = SCAN;
                    if (restart_q || win_start) begin
                        clear     = 1'b1;
                        restart_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Bitmap, pending counter, overrun flag and query result.
    always_comb begin
        win_open = (state_q != IDLE);
        ack      = (state_q == REQ) && ref_ready;
        ack_new  = ack && !fresh_q[ref_addr_q];
        // Same row acked and written counts once.
        user_new = user_we && !fresh_q[user_addr] && !(ack_new && (user_addr == ref_addr_q));
        dec      = {1'b0, ack_new} + {1'b0, user_new};

        // Clear beats ack; user write beats clear.
        fresh_d = fresh_q;
        if (ack) fresh_d[ref_addr_q] = 1'b1;
        if (clear) fresh_d = '0;
        if (user_we) fresh_d[user_addr] = 1'b1;

        pending_d = pending_q;
        if (clear) begin
            pending_d = user_we ? CNT_W'(NUM_ROWS - 1) : CNT_W'(NUM_ROWS);
        end else if (win_open) begin
            pending_d = (pending_q >= CNT_W'(dec)) ? pending_q - CNT_W'(dec) : '0;
        end

        overrun_d = overrun_q;
        if (win_start && win_open) begin
            overrun_d = 1'b1;
        end else if (overrun_clr) begin
            overrun_d = 1'b0;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            fresh_q     <= '0;
            timer_q     <= '0;
            pending_q   <= '0;
            ref_addr_q  <= '0;
            ref_valid_q <= 1'b0;
            restart_q   <= 1'b0;
            overrun_q   <= 1'b0;
            user_hit_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            fresh_q     <= fresh_d;
            timer_q     <= timer_d;
            pending_q   <= pending_d;
            ref_addr_q  <= ref_addr_d;
            ref_valid_q <= ref_valid_d;
            restart_q   <= restart_d;
            overrun_q   <= overrun_d;
            user_hit_q  <= fresh_q[user_addr];
        end
    end

    assign ref_valid = ref_valid_q;
    assign ref_addr  = ref_addr_q;
    assign user_hit  = user_hit_q;
    assign pending   = pending_q;
    assign done      = (state_q == IDLE);
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_refresh_skip_scheduler.sv
// Directed self-checking bench for refresh_skip_scheduler (128 rows, 300-cycle retention).
module tb_refresh_skip_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       start = 1'b0;
    logic       user_we = 1'b0;
    logic [6:0] user_addr = '0;
    logic       ref_valid;
    logic [6:0] ref_addr;
    logic       ref_ready = 1'b0;
    logic       user_hit;
    logic [7:0] pending;
    logic       done;
    logic       overrun;
    logic       overrun_clr = 1'b0;

    int errors = 0;
    int checks = 0;

    refresh_skip_scheduler #(
        .NUM_ROWS         (128),
        .RETENTION_CYCLES (300)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .start       (start),
        .user_we     (user_we),
        .user_addr   (user_addr),
        .ref_valid   (ref_valid),
        .ref_addr    (ref_addr),
        .ref_ready   (ref_ready),
        .user_hit    (user_hit),
        .pending     (pending),
        .done        (done),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (ref_valid !== 1'b0) begin errors++; $display("FAIL reset_ref_valid got=%0b exp=0", ref_valid); end
        checks++; if (ref_addr !== 7'd0) begin errors++; $display("FAIL reset_ref_addr got=%0d exp=0", ref_addr); end
        checks++; if (user_hit !== 1'b0) begin errors++; $display("FAIL reset_user_hit got=%0b exp=0", user_hit); end
        checks++; if (pending !== 8'd0) begin errors++; $display("FAIL reset_pending got=%0d exp=0", pending); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL reset_done got=%0b exp=1", done); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%0b exp=0", overrun); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_full_window();
        int seen = 0;
        int bad = 0;
        int done_cyc = 0;
        ref_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (pending !== 8'd128) begin errors++; $display("FAIL full_pending_start got=%0d exp=128", pending); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL full_done_start got=%0b exp=0", done); end
        for (int c = 1; c <= 400; c++) begin
            tick();
            if (ref_valid) begin
                if (int'(ref_addr) != seen) bad++;
                if (int'(pending) != 128 - seen) bad++;
                seen++;
            end
            if (done) begin
                done_cyc = c;
                break;
            end
        end
        checks++; if (done_cyc != 257) begin errors++; $display("FAIL full_done_cycle got=%0d exp=257", done_cyc); end
        checks++; if (seen != 128) begin errors++; $display("FAIL full_req_count got=%0d exp=128", seen); end
        checks++; if (bad != 0) begin errors++; $display("FAIL full_addr_pending_seq got=%0d bad exp=0", bad); end
        checks++; if (pending !== 8'd0) begin errors++; $display("FAIL full_pending_end got=%0d exp=0", pending); end
    endtask

    task automatic test_skip();
        int reqs = 0;
        int hits = 0;
        ref_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 400; c++) begin
            user_we   = (c <= 3);
            user_addr = (c == 1) ? 7'd3 : (c == 2) ? 7'd4 : 7'd127;
            tick();
            if (ref_valid) begin
                reqs++;
                if (ref_addr == 7'd3 || ref_addr == 7'd4 || ref_addr == 7'd127) hits++;
            end
            if (done) break;
        end
        user_we = 1'b0;
        checks++; if (reqs != 125) begin errors++; $display("FAIL skip_req_count got=%0d exp=125", reqs); end
        checks++; if (hits != 0) begin errors++; $display("FAIL skip_written_requested got=%0d exp=0", hits); end
        checks++; if (pending !== 8'd0) begin errors++; $display("FAIL skip_pending_end got=%0d exp=0", pending); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL skip_done got=%0b exp=1", done); end
        user_addr = 7'd3;
        tick();
        checks++; if (user_hit !== 1'b1) begin errors++; $display("FAIL skip_user_hit got=%0b exp=1", user_hit); end
    endtask

    task automatic test_stall();
        logic found = 1'b0;
        int unstable = 0;
        int pbad = 0;
        ref_ready = 1'b0;
        user_addr = 7'd50;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (user_hit !== 1'b1) begin errors++; $display("FAIL stall_hit_preclear got=%0b exp=1", user_hit); end
        tick();
        checks++; if (user_hit !== 1'b0) begin errors++; $display("FAIL stall_hit_cleared got=%0b exp=0", user_hit); end
        checks++; if (ref_valid !== 1'b1 || ref_addr !== 7'd0) begin errors++; $display("FAIL stall_first_req got=%0b/%0d exp=1/0", ref_valid, ref_addr); end
        ref_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (ref_valid && ref_addr == 7'd5) begin
                found = 1'b1;
                break;
            end
        end
        ref_ready = 1'b0;
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL stall_reach_row5 got=%0b exp=1", found); end
        checks++; if (pending !== 8'd123) begin errors++; $display("FAIL stall_pending_before got=%0d exp=123", pending); end
        user_addr = 7'd5;
        for (int i = 0; i < 10; i++) begin
            user_we = (i == 4);
            tick();
            if (!(ref_valid === 1'b1 && ref_addr === 7'd5)) unstable++;
            if (i < 4 && pending !== 8'd123) pbad++;
            if (i >= 4 && pending !== 8'd122) pbad++;
        end
        user_we = 1'b0;
        checks++; if (unstable != 0) begin errors++; $display("FAIL stall_req_stable got=%0d unstable exp=0", unstable); end
        checks++; if (pbad != 0) begin errors++; $display("FAIL stall_pending_steps got=%0d bad exp=0", pbad); end
        ref_ready = 1'b1;
        tick();
        checks++; if (ref_valid !== 1'b0) begin errors++; $display("FAIL stall_ack_valid got=%0b exp=0", ref_valid); end
        checks++; if (pending !== 8'd122) begin errors++; $display("FAIL stall_ack_fresh_row got=%0d exp=122", pending); end
    endtask

    task automatic test_dual_decrement();
        int got [2];
        int n = 0;
        ref_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (ref_valid && ref_addr == 7'd7) break;
        end
        checks++; if (pending !== 8'd121) begin errors++; $display("FAIL dual_pending_before got=%0d exp=121", pending); end
        user_we = 1'b1;
        user_addr = 7'd9;
        tick();
        user_we = 1'b0;
        checks++; if (pending !== 8'd119) begin errors++; $display("FAIL dual_pending_after got=%0d exp=119", pending); end
        got[0] = -1;
        got[1] = -1;
        for (int c = 0; c < 20 && n < 2; c++) begin
            tick();
            if (ref_valid) begin
                got[n] = int'(ref_addr);
                n++;
            end
        end
        checks++; if (got[0] != 8) begin errors++; $display("FAIL dual_next_req got=%0d exp=8", got[0]); end
        checks++; if (got[1] != 10) begin errors++; $display("FAIL dual_skip_row9 got=%0d exp=10", got[1]); end
    endtask

    task automatic test_restart_in_req();
        for (int c = 0; c < 20; c++) begin
            tick();
            if (ref_valid && ref_addr == 7'd12) break;
        end
        ref_ready = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL restart_overrun got=%0b exp=1", overrun); end
        checks++; if (ref_valid !== 1'b1 || ref_addr !== 7'd12) begin errors++; $display("FAIL restart_req_held got=%0b/%0d exp=1/12", ref_valid, ref_addr); end
        ref_ready = 1'b1;
        tick();
        ref_ready = 1'b0;
        checks++; if (ref_valid !== 1'b0) begin errors++; $display("FAIL restart_handshake got=%0b exp=0", ref_valid); end
        checks++; if (pending !== 8'd128) begin errors++; $display("FAIL restart_pending got=%0d exp=128", pending); end
        tick();
        checks++; if (ref_valid !== 1'b1 || ref_addr !== 7'd0) begin errors++; $display("FAIL restart_rescan got=%0b/%0d exp=1/0", ref_valid, ref_addr); end
        start = 1'b1;
        overrun_clr = 1'b1;
        tick();
        start = 1'b0;
        overrun_clr = 1'b0;
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL restart_set_beats_clr got=%0b exp=1", overrun); end
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL restart_overrun_clr got=%0b exp=0", overrun); end
    endtask

    task automatic test_timer();
        int c1 = 0;
        int c2 = 0;
        int drops = 0;
        logic seen_done = 1'b0;
        rst = 1'b1;
        ref_ready = 1'b1;
        #3;
        @(negedge clk);
        rst = 1'b0;
        en = 1'b1;
        for (int c = 1; c <= 400; c++) begin
            tick();
            if (!done) begin
                c1 = c;
                break;
            end
        end
        checks++; if (c1 != 300) begin errors++; $display("FAIL timer_first_start got=%0d exp=300", c1); end
        for (int c = 1; c <= 400; c++) begin
            tick();
            if (done) seen_done = 1'b1;
            if (!done && seen_done) begin
                c2 = c;
                break;
            end
        end
        en = 1'b0;
        checks++; if (c2 != 300) begin errors++; $display("FAIL timer_period got=%0d exp=300", c2); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL timer_no_overrun got=%0b exp=0", overrun); end
        for (int c = 0; c < 300; c++) begin
            tick();
            if (done) break;
        end
        for (int c = 0; c < 700; c++) begin
            tick();
            if (!done) drops++;
        end
        checks++; if (drops != 0) begin errors++; $display("FAIL timer_frozen got=%0d open cycles exp=0", drops); end
        user_addr = 7'd50;
        user_we = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        user_we = 1'b0;
        checks++; if (pending !== 8'd127) begin errors++; $display("FAIL timer_write_at_clear got=%0d exp=127", pending); end
        repeat (21) tick();
        checks++; if (ref_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_valid got=%0b exp=1", ref_valid); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL rst_async_done got=%0b exp=1", done); end
        checks++; if (ref_valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid got=%0b exp=0", ref_valid); end
        checks++; if (pending !== 8'd0) begin errors++; $display("FAIL rst_async_pending got=%0d exp=0", pending); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_full_window();
        test_skip();
        test_stall();
        test_dual_decrement();
        test_restart_in_req();
        test_timer();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
